// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, LUI and load/store address generation into a registered
// result bundle for MEM, with an optional 1-bit-per-cycle serial shifter.
module ex_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter bit SHIFT_SERIAL = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [2:0]        op_in,
  input  logic [2:0]        fun_in,
  input  logic [DATA_W-1:0] rs1_in,
  input  logic [DATA_W-1:0] rs2_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              rec_in,
  input  logic              stall_in,
  output logic              busy_out,
  output logic              valid_out,
  output logic [2:0]        op_out,
  output logic [2:0]        fun_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic              wb_en_out
);

  localparam logic [2:0] OP_RR    = 3'd1;
  localparam logic [2:0] OP_RI    = 3'd2;
  localparam logic [2:0] OP_LUI   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_valid;
  logic [2:0]          r_op;
  logic [2:0]          r_fun;
  logic [REG_W-1:0]    r_rd;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_store_data;
  logic                r_wb_en;
  logic [DATA_W-1:0]   r_acc;
  logic [4:0]          r_cnt;
  logic                r_shift_left;
  logic                r_shift_arith;
  logic                r_wb_pending;

  logic [DATA_W-1:0]   w_b;
  logic [4:0]          w_shamt;
  logic [DATA_W-1:0]   w_alu;
  logic [DATA_W-1:0]   w_result;
  logic [DATA_W-1:0]   w_store_data;
  logic                w_wb_en;
  logic                w_is_alu;
  logic                w_accept;
  logic                w_shift_start;
  logic [DATA_W-1:0]   w_acc_next;
  logic                w_load;
  logic                w_shift_load;
  logic                w_shift_step;
  logic                w_shift_done;
  logic                w_drop;

  assign busy_out       = (r_state == ST_SHIFT) | (r_valid & stall_in);
  assign w_accept       = rec_in & ~busy_out;
  assign valid_out      = r_valid;
  assign op_out         = r_op;
  assign fun_out        = r_fun;
  assign rd_out         = r_rd;
  assign result_out     = r_result;
  assign store_data_out = r_store_data;
  assign wb_en_out      = r_wb_en;

  // Operand select, ALU and per-op result for the single-cycle path
  always_comb begin
    w_is_alu = (op_in == OP_RR) || (op_in == OP_RI);
    if (op_in == OP_RR) begin
      w_b = rs2_in;
    end else begin
      w_b = imm_in;
    end
    w_shamt = w_b[4:0];
    case (fun_in)
      3'b000: begin
        if ((op_in == OP_RR) && imm_in[10]) begin
          w_alu = rs1_in - w_b;
        end else begin
          w_alu = rs1_in + w_b;
        end
      end
      3'b001: w_alu = rs1_in << w_shamt;
      3'b010: w_alu = {{(DATA_W-1){1'b0}}, ($signed(rs1_in) < $signed(w_b))};
      3'b011: w_alu = {{(DATA_W-1){1'b0}}, (rs1_in < w_b)};
      3'b100: w_alu = rs1_in ^ w_b;
      3'b101: begin
        if (imm_in[10]) begin
          w_alu = $signed(rs1_in) >>> w_shamt;
        end else begin
          w_alu = rs1_in >> w_shamt;
        end
      end
      3'b110: w_alu = rs1_in | w_b;
      3'b111: w_alu = rs1_in & w_b;
      default: w_alu = {DATA_W{1'b0}};
    endcase
    case (op_in)
      OP_RR, OP_RI:      w_result = w_alu;
      OP_LUI:            w_result = imm_in;
      OP_LOAD, OP_STORE: w_result = rs1_in + imm_in;
      default:           w_result = {DATA_W{1'b0}};
    endcase
    if (op_in == OP_STORE) begin
      w_store_data = rs2_in;
    end else begin
      w_store_data = {DATA_W{1'b0}};
    end
    w_wb_en = (rd_in != {REG_W{1'b0}}) && (op_in >= OP_RR) && (op_in <= OP_LOAD);
  end

  assign w_shift_start = w_accept & w_is_alu & (fun_in[1:0] == 2'b01) &
                         (w_shamt != 5'd0) & (SHIFT_SERIAL != 1'b0);

  // Serial shifter: one bit per edge, right shifts optionally sign-filling
  always_comb begin
    if (r_shift_left) begin
      w_acc_next = {r_acc[DATA_W-2:0], 1'b0};
    end else if (r_shift_arith) begin
      w_acc_next = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
    end else begin
      w_acc_next = {1'b0, r_acc[DATA_W-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_shift_start) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt <= 5'd1) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM control outputs; a count of 0 in SHIFT is treated as the last step
  always_comb begin
    w_load       = 1'b0;
    w_shift_load = 1'b0;
    w_shift_step = 1'b0;
    w_shift_done = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_shift_start) begin
          w_shift_load = 1'b1;
        end else if (w_accept) begin
          w_load = 1'b1;
        end else if (!(r_valid && stall_in)) begin
          w_drop = 1'b1;
        end else begin
          w_drop = 1'b0;
        end
      end
      ST_SHIFT: begin
        w_shift_step = 1'b1;
        if (r_cnt <= 5'd1) begin
          w_shift_done = 1'b1;
        end else begin
          w_shift_done = 1'b0;
        end
      end
      default: w_drop = 1'b1;
    endcase
  end

  // Output bundle and shifter state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid       <= 1'b0;
      r_op          <= 3'd0;
      r_fun         <= 3'd0;
      r_rd          <= {REG_W{1'b0}};
      r_result      <= {DATA_W{1'b0}};
      r_store_data  <= {DATA_W{1'b0}};
      r_wb_en       <= 1'b0;
      r_acc         <= {DATA_W{1'b0}};
      r_cnt         <= 5'd0;
      r_shift_left  <= 1'b0;
      r_shift_arith <= 1'b0;
      r_wb_pending  <= 1'b0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_op         <= op_in;
      r_fun        <= fun_in;
      r_rd         <= rd_in;
      r_result     <= w_result;
      r_store_data <= w_store_data;
      r_wb_en      <= w_wb_en;
    end else if (w_shift_load) begin
      r_valid       <= 1'b0;
      r_wb_en       <= 1'b0;
      r_op          <= op_in;
      r_fun         <= fun_in;
      r_rd          <= rd_in;
      r_result      <= {DATA_W{1'b0}};
      r_store_data  <= {DATA_W{1'b0}};
      r_acc         <= rs1_in;
      r_cnt         <= w_shamt;
      r_shift_left  <= ~fun_in[2];
      r_shift_arith <= imm_in[10];
      r_wb_pending  <= w_wb_en;
    end else if (w_shift_step) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - 5'd1;
      if (w_shift_done) begin
        r_result <= w_acc_next;
        r_valid  <= 1'b1;
        r_wb_en  <= r_wb_pending;
      end
    end else if (w_drop) begin
      r_valid <= 1'b0;
      r_wb_en <= 1'b0;
    end
  end

endmodule
